// File: rtl/atctlc2axi500_rsp_collector_pkg.sv
// Shared definitions for the atctlc2axi500 read-response collector:
// FSM state encoding, AXI RESP codes and a RESP error-decode helper.
package atctlc2axi500_rsp_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CPL  = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // SLVERR and DECERR are errors; OKAY and EXOKAY are not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/atctlc2axi500_rsp_collector.sv
// Read-response collector: accepts one expected-burst descriptor, forwards
// the matching AXI R beats to the TLC side with zero latency, checks beat
// count / RLAST / RID, and issues one completion with aggregated status.
// Ports:
//   clk, reset           clock, async active-high reset
//   cmd_*                expected burst descriptor (len = beats-1, id)
//   axi_r*               AXI R channel (slave side of the collector)
//   tlc_r*               TLC beat stream (pass-through of AXI R)
//   cpl_*                per-burst completion with error flags
module atctlc2axi500_rsp_collector
    import atctlc2axi500_rsp_collector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast,
    input  logic [ID_WIDTH-1:0]   axi_rid,
    output logic                  tlc_rvalid,
    input  logic                  tlc_rready,
    output logic [DATA_WIDTH-1:0] tlc_rdata,
    output logic                  tlc_rerr,
    output logic                  tlc_rlast,
    output logic                  cpl_valid,
    input  logic                  cpl_ready,
    output logic                  cpl_err,
    output logic                  cpl_proto_err
);

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [ID_WIDTH-1:0]   exp_id_q, exp_id_d;
    logic                  err_q, err_d;
    logic                  proto_q, proto_d;

    logic in_data;
    logic last_exp;
    logic beat_fire;

    assign in_data   = (state_q == ST_DATA);
    assign last_exp  = (rem_q == '0);
    assign beat_fire = in_data && axi_rvalid && tlc_rready;

    // Handshake and pass-through outputs decoded from the registered state.
    assign cmd_ready     = (state_q == ST_IDLE);
    assign axi_rready    = in_data && tlc_rready;
    assign tlc_rvalid    = in_data && axi_rvalid;
    assign tlc_rdata     = axi_rdata;
    assign tlc_rerr      = resp_is_err(axi_rresp);
    assign tlc_rlast     = last_exp;
    assign cpl_valid     = (state_q == ST_CPL);
    assign cpl_err       = cpl_valid && err_q;
    assign cpl_proto_err = cpl_valid && proto_q;

    // Next-state and burst bookkeeping.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        exp_id_d = exp_id_q;
        err_d    = err_q;
        proto_d  = proto_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rem_d    = cmd_len;
                    exp_id_d = cmd_id;
                    err_d    = 1'b0;
                    proto_d  = 1'b0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat_fire) begin
                    err_d   = err_q | resp_is_err(axi_rresp);
                    // Flags wrong RID, early RLAST and missing RLAST alike.
                    proto_d = proto_q | (axi_rid != exp_id_q) | (axi_rlast != last_exp);
                    if (!last_exp) begin
                        rem_d = rem_q - LEN_WIDTH'(1);
                    end
                    // Either the expected count or RLAST ends the burst.
                    if (last_exp || axi_rlast) begin
                        state_d = ST_CPL;
                    end
                end
            end
            ST_CPL: begin
                if (cpl_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            exp_id_q <= '0;
            err_q    <= 1'b0;
            proto_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            exp_id_q <= exp_id_d;
            err_q    <= err_d;
            proto_q  <= proto_d;
        end
    end

endmodule

// File: tb/tb_atctlc2axi500_rsp_collector.sv
// Scoreboard bench for atctlc2axi500_rsp_collector.
module tb_atctlc2axi500_rsp_collector;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;
    localparam int unsigned IW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic err;
        logic proto;
    } cpl_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len;
    logic [IW-1:0] cmd_id;
    logic          axi_rvalid;
    logic          axi_rready;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;
    logic [IW-1:0] axi_rid;
    logic          tlc_rvalid;
    logic          tlc_rready;
    logic [DW-1:0] tlc_rdata;
    logic          tlc_rerr;
    logic          tlc_rlast;
    logic          cpl_valid;
    logic          cpl_ready;
    logic          cpl_err;
    logic          cpl_proto_err;

    beat_t exp_beats[$];
    cpl_t  exp_cpls[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    beats_seen = 0;
    bit    rand_rdy = 1'b0;

    atctlc2axi500_rsp_collector #(
        .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rid(axi_rid),
        .tlc_rvalid(tlc_rvalid), .tlc_rready(tlc_rready), .tlc_rdata(tlc_rdata),
        .tlc_rerr(tlc_rerr), .tlc_rlast(tlc_rlast),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_err(cpl_err),
        .cpl_proto_err(cpl_proto_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // TLC-side ready: always high, or random when stalls are enabled.
    initial begin
        tlc_rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tlc_rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on every TLC beat and completion fire.
    initial begin
        bit   cpl_wait = 1'b0;
        cpl_t cpl_prev = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cpl_wait = 1'b0;
            end else begin
                if (tlc_rvalid && tlc_rready) begin
                    beats_seen++;
                    check_eq("rready_pass", 64'(axi_rready), 64'd1);
                    check_eq("beat_expected", 64'(exp_beats.size() > 0), 64'd1);
                    if (exp_beats.size() > 0) begin
                        beat_t b;
                        b = exp_beats.pop_front();
                        check_eq("tlc_rdata", 64'(tlc_rdata), 64'(b.data));
                        check_eq("tlc_rerr", 64'(tlc_rerr), 64'(b.err));
                        check_eq("tlc_rlast", 64'(tlc_rlast), 64'(b.last));
                    end
                end
                if (cpl_valid) begin
                    check_eq("cpl_no_tlc_vld", 64'(tlc_rvalid), 64'd0);
                    check_eq("cpl_no_axi_rdy", 64'(axi_rready), 64'd0);
                    check_eq("cpl_no_cmd_rdy", 64'(cmd_ready), 64'd0);
                    if (cpl_wait) begin
                        check_eq("cpl_err_stable", 64'(cpl_err), 64'(cpl_prev.err));
                        check_eq("cpl_proto_stable", 64'(cpl_proto_err), 64'(cpl_prev.proto));
                    end
                    cpl_prev = '{err: cpl_err, proto: cpl_proto_err};
                    cpl_wait = !cpl_ready;
                    if (cpl_ready) begin
                        check_eq("cpl_expected", 64'(exp_cpls.size() > 0), 64'd1);
                        if (exp_cpls.size() > 0) begin
                            cpl_t c;
                            c = exp_cpls.pop_front();
                            check_eq("cpl_err", 64'(cpl_err), 64'(c.err));
                            check_eq("cpl_proto_err", 64'(cpl_proto_err), 64'(c.proto));
                        end
                    end
                end else begin
                    cpl_wait = 1'b0;
                end
            end
        end
    end

    // All drivers enter and leave just after a rising edge.
    task automatic send_cmd(input int len, input int id);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        cmd_id    = IW'(id);
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            waited++;
            if (waited > 100) begin
                check_eq("cmd_timeout", 64'(waited), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] data, input logic [1:0] resp, input logic last,
                             input int rid, input logic exp_last, input int gap);
        int waited = 0;
        if (gap > 0) begin
            axi_rvalid = 1'b0;
            repeat (gap) begin
                @(negedge clk);
                check_eq("stall_no_vld", 64'(tlc_rvalid), 64'd0);
                @(posedge clk);
                #1;
            end
        end
        axi_rvalid = 1'b1;
        axi_rdata  = data;
        axi_rresp  = resp;
        axi_rlast  = last;
        axi_rid    = IW'(rid);
        exp_beats.push_back('{data: data, err: resp[1], last: exp_last});
        forever begin
            @(negedge clk);
            check_eq("tlc_vld_held", 64'(tlc_rvalid), 64'd1);
            if (axi_rready) break;
            waited++;
            if (waited > 200) begin
                check_eq("beat_timeout", 64'(waited), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // rlast_at: -1 = on the expected last beat, -2 = never, k = on beat k.
    task automatic run_burst(input int len, input int id, input int rlast_at, input int bad_rid_at,
                             input int err_mask, input bit stall, input int cpl_hold);
        cpl_t c = '0;
        int   sent = 0;
        int   seen0;
        send_cmd(len, id);
        seen0 = beats_seen;
        for (int i = 0; i <= len; i++) begin
            logic       last_flag;
            logic [1:0] resp;
            int         rid;
            last_flag = (rlast_at == -1) ? (i == len) : (rlast_at == i);
            resp      = err_mask[i] ? 2'b10 : 2'b00;
            rid       = (i == bad_rid_at) ? id + 1 : id;
            c.err     = c.err | resp[1];
            c.proto   = c.proto | (rid != id) | (last_flag != (i == len));
            send_beat(DW'($urandom), resp, last_flag, rid, (i == len),
                      stall ? $urandom_range(0, 2) : 0);
            sent++;
            if (last_flag || i == len) break;
        end
        axi_rvalid = 1'b0;
        exp_cpls.push_back(c);
        @(negedge clk);
        check_eq("cpl_timing", 64'(cpl_valid), 64'd1);
        check_eq("beats_fwd", 64'(beats_seen - seen0), 64'(sent));
        repeat (cpl_hold) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_eq("cpl_vld_hold", 64'(cpl_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        cpl_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        cpl_ready = 1'b0;
        @(negedge clk);
        check_eq("cmd_rdy_after_cpl", 64'(cmd_ready), 64'd1);
        check_eq("cpl_dropped", 64'(cpl_valid), 64'd0);
        check_eq("cpl_q_empty", 64'(exp_cpls.size()), 64'd0);
        check_eq("beat_q_empty", 64'(exp_beats.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_len    = '0;
        cmd_id     = '0;
        axi_rvalid = 1'b0;
        axi_rdata  = '0;
        axi_rresp  = 2'b00;
        axi_rlast  = 1'b0;
        axi_rid    = '0;
        cpl_ready  = 1'b0;
        #2;
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_axi_rready", 64'(axi_rready), 64'd0);
        check_eq("rst_tlc_rvalid", 64'(tlc_rvalid), 64'd0);
        check_eq("rst_cpl_valid", 64'(cpl_valid), 64'd0);
        check_eq("rst_cpl_err", 64'(cpl_err), 64'd0);
        check_eq("rst_cpl_proto", 64'(cpl_proto_err), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Clean 4-beat burst.
        run_burst(3, 5, -1, -1, 0, 1'b0, 0);
        // Single beat with SLVERR.
        run_burst(0, 5, -1, -1, 1, 1'b0, 0);
        // Early RLAST on beat 2 of 4.
        run_burst(3, 5, 1, -1, 0, 1'b0, 0);
        // Wrong RID on beat 2 and missing RLAST.
        run_burst(1, 5, -2, 1, 0, 1'b0, 0);
        // Random stalls on both sides, completion held off 3 cycles.
        rand_rdy = 1'b1;
        run_burst(7, 9, -1, -1, 8'h24, 1'b1, 3);
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        // Reset after beat 2 of 4: partial burst is dropped, no completion.
        send_cmd(3, 2);
        send_beat(DW'($urandom), 2'b00, 1'b0, 2, 1'b0, 0);
        send_beat(DW'($urandom), 2'b10, 1'b0, 2, 1'b0, 0);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("mid_rst_axi_rready", 64'(axi_rready), 64'd0);
        check_eq("mid_rst_tlc_rvalid", 64'(tlc_rvalid), 64'd0);
        check_eq("mid_rst_cpl_valid", 64'(cpl_valid), 64'd0);
        axi_rvalid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cmd_valid = 1'b1;
        cmd_len   = LW'(1);
        cmd_id    = IW'(3);
        @(negedge clk);
        check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("post_rst_no_cpl", 64'(cpl_valid), 64'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("post_rst_accepted", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        send_beat(DW'($urandom), 2'b00, 1'b0, 3, 1'b0, 0);
        send_beat(DW'($urandom), 2'b01, 1'b1, 3, 1'b1, 0);
        axi_rvalid = 1'b0;
        exp_cpls.push_back('{err: 1'b0, proto: 1'b0});
        cpl_ready = 1'b1;
        @(negedge clk);
        check_eq("post_rst_cpl", 64'(cpl_valid), 64'd1);
        @(posedge clk);
        #1;
        cpl_ready = 1'b0;
        @(negedge clk);
        check_eq("post_rst_idle", 64'(cmd_ready), 64'd1);
        check_eq("final_cpl_q_empty", 64'(exp_cpls.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/atctlc2axi500_rsp_collector.md
# atctlc2axi500_rsp_collector

Read-response collector on the AXI-to-TLC return path of the atctlc2axi500 bridge. It accepts the expected burst length and ID of one outstanding AXI read, then passes the matching R-channel beats to the TLC side with valid/ready handshakes. It checks beat count, RLAST and RID against the expected values and merges per-beat RRESP errors. When the burst ends, it issues one completion carrying the aggregated error status.

## Interface
Parameters:
- DATA_WIDTH, 32, R data width
- LEN_WIDTH, 8, burst length field width (AXI len encoding, beats-1)
- ID_WIDTH, 4, AXI ID width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  expected-burst descriptor valid
- cmd_ready  out  1  descriptor accepted; high only in IDLE
- cmd_len  in  LEN_WIDTH  expected beats minus one
- cmd_id  in  ID_WIDTH  expected RID
- axi_rvalid  in  1  AXI R beat valid
- axi_rready  out  1  AXI R beat ready
- axi_rdata  in  DATA_WIDTH  AXI R data
- axi_rresp  in  2  AXI R response
- axi_rlast  in  1  AXI R last
- axi_rid  in  ID_WIDTH  AXI R ID
- tlc_rvalid  out  1  TLC beat valid
- tlc_rready  in  1  TLC beat ready
- tlc_rdata  out  DATA_WIDTH  beat data
- tlc_rerr  out  1  beat error (axi_rresp[1])
- tlc_rlast  out  1  final expected beat
- cpl_valid  out  1  burst completion valid
- cpl_ready  in  1  completion accepted
- cpl_err  out  1  OR of all beat errors in burst
- cpl_proto_err  out  1  RLAST/RID/length mismatch seen

## Operation
- State machine with three states: IDLE, DATA and CPL. Reset state is IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd fire: load rem=cmd_len and exp_id=cmd_id; clear err and proto; go to DATA.
- DATA:
  - tlc_rvalid=axi_rvalid; axi_rready=tlc_rready.
  - tlc_rdata, tlc_rerr and tlc_rlast=(rem==0) are combinational pass-through.
- Beat fire (axi_rvalid & tlc_rready in DATA):
  - err |= axi_rresp[1].
  - proto |= (axi_rid!=exp_id) | (axi_rlast != (rem==0)).
  - rem decrements by 1 (LEN_WIDTH wide; never wraps because the exit occurs at 0).
- Exit DATA to CPL on a beat fire with either rem==0 or axi_rlast=1:
  - Early RLAST truncates the burst and sets proto.
  - A missing RLAST on the expected last beat sets proto.
- CPL:
  - cpl_valid=1, with cpl_err=err and cpl_proto_err=proto held stable.
  - axi_rready=0, tlc_rvalid=0, cmd_ready=0.
  - On cpl_ready go to IDLE.
- Outside DATA: axi_rready=0 and tlc_rvalid=0. R beats stall upstream; none are dropped.
- Reset mid-burst: state returns to IDLE immediately (asynchronous). The partial burst is discarded and no completion is issued.

## Timing
- Output values during reset:
  - cmd_ready=1.
  - axi_rready, tlc_rvalid, cpl_valid, cpl_err and cpl_proto_err are all 0.
  - tlc_rdata, tlc_rerr and tlc_rlast are don't-care while tlc_rvalid=0.
- Beat path has zero latency, combinational in both directions.
- cmd fire at cycle N: first beat can be accepted at N+1.
- Last beat fire at cycle M: cpl_valid is high from M+1.
- cpl fire at cycle K: cmd_ready is high from K+1.
- Minimum burst period is len+1 beats plus 2 overhead cycles.
- Handshake rules:
  - tlc_rvalid must not drop without a fire while axi_rvalid is held.
  - cpl_valid holds until cpl_ready.
- A single-beat burst (cmd_len=0) goes DATA→CPL on its first beat.
- Registers: state, rem, exp_id, err, proto. No datapath storage.

## Structure
- The shared atctlc2axi500 package holds:
  - state encoding localparams (IDLE, DATA, CPL)
  - AXI RESP constants: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
- No sub-module; the counter and FSM are inline.
- When decoupling is required, the integrator places atctlc2axi500_sync_fifo externally on the tlc_r* side.

## Test plan
- cmd_len=3, cmd_id=5; 4 beats with RID=5, OKAY, RLAST on beat 4, tlc_rready=1 → 4 TLC beats with tlc_rlast on beat 4; cpl_valid the next cycle with err=0 and proto=0.
- cmd_len=0; 1 beat with rresp=SLVERR and rlast=1 → tlc_rerr=1, tlc_rlast=1; cpl_err=1, cpl_proto_err=0.
- cmd_len=3; RLAST on beat 2 → the burst ends after 2 TLC beats; cpl_proto_err=1; axi_rready=0 thereafter.
- cmd_len=1; beat 2 has RID=6 against expected 5, and RLAST is absent → cpl_proto_err=1; exactly 2 beats are forwarded.
- Random tlc_rready and axi_rvalid stalls over cmd_len=7 → data order is preserved with no duplicates; cpl_ready held low 3 cycles → cpl_valid and cpl fields stay stable; cmd_ready rises the cycle after cpl fire.
- Assert reset after beat 2 of 4 → outputs go to reset values immediately; no cpl_valid; the next cmd is accepted the cycle after reset deasserts.
